exibe_sequencia: RTL and testbench
==================================

EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

Interface
REQ-001 Parameter T_ON, default 1000: clock cycles each sequence item is lit; SHALL be ≥1.
REQ-002 Parameter T_OFF, default 500: clock cycles of dark gap after each item; SHALL be ≥1.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iniciar  input  1  start request; sampled only in INICIAL.
REQ-006 rodada  input  4  index of the last item to show (inclusive); sampled with iniciar.
REQ-007 mem_addr  output  4  address to sync_ram_16x4 (1-cycle read latency).
REQ-008 mem_dado  input  4  read data from that RAM.
REQ-009 leds  output  4  registered LED drive presented to the player.
REQ-010 exibindo  output  1  high in every state except INICIAL.
REQ-011 pronto  output  1  one-cycle pulse when the sequence is complete.
REQ-012 db_endereco  output  4  copy of mem_addr.
REQ-013 db_estado  output  4  current state encoding.

Function
REQ-014 States SHALL be INICIAL, ESPERA_MEM, CAPTURA, ACENDE, APAGA, FIM.
REQ-015 INICIAL with iniciar=1: addr←0, rodada_reg←rodada, next ESPERA_MEM; iniciar=0: stay.
REQ-016 ESPERA_MEM SHALL last exactly 1 cycle (RAM samples addr), then CAPTURA.
REQ-017 CAPTURA SHALL last 1 cycle: leds←mem_dado at its closing edge, timer cleared, next ACENDE.
REQ-018 ACENDE SHALL last exactly T_ON cycles, leds held; on exit leds←0, timer cleared, next APAGA.
REQ-019 APAGA SHALL last exactly T_OFF cycles with leds=0.
REQ-020 APAGA exit: addr==rodada_reg → FIM; else addr←addr+1, next ESPERA_MEM.
REQ-021 FIM SHALL last 1 cycle with pronto=1, then INICIAL.
REQ-022 Latency: leds valid 2 cycles after the edge sampling iniciar; each item occupies 2+T_ON+T_OFF cycles; pronto asserted (rodada+1)·(2+T_ON+T_OFF) cycles after that edge.
REQ-023 rodada=15 SHALL show all 16 items; addr SHALL never wrap past rodada_reg.
REQ-024 iniciar asserted outside INICIAL SHALL be ignored; rodada changes after sampling SHALL have no effect.
REQ-025 iniciar high in FIM SHALL be ignored; a new run starts only from INICIAL.
REQ-026 leds SHALL be 0 in INICIAL, ESPERA_MEM, CAPTURA, APAGA and FIM.

Reset
REQ-027 reset SHALL force INICIAL, addr=0, rodada_reg=0, timer=0, leds=0, pronto=0, exibindo=0.
REQ-028 reset mid-sequence SHALL abort without a pronto pulse; reset has priority over iniciar in the same cycle.

Structure
REQ-029 State encodings and the 4-bit data/address width constants SHALL live in shared package genius_pkg.
REQ-030 The dwell timer SHALL be one instance of the existing contador_m, cleared synchronously on entry to ACENDE/APAGA.
REQ-031 The RAM SHALL be external; this block contains no storage beyond addr, rodada_reg, leds, state, timer.

Verification (T_ON=4, T_OFF=2; RAM preloaded 1,2,4,8,…)
REQ-032 reset, iniciar pulse with rodada=0 -> leds=0001 for 4 cycles from cycle 2, then 0 for 2, pronto at cycle 8, exibindo low at cycle 9.
REQ-033 rodada=3 -> leds sequence 1,2,4,8, each 4 cycles lit, gaps of 0, pronto exactly once at cycle 32.
REQ-034 rodada=15 -> mem_addr walks 0..15 with no wrap, pronto at cycle 128.
REQ-035 iniciar held high throughout and rodada changed mid-run -> single run of original length, restarts only after returning to INICIAL.
REQ-036 reset asserted during ACENDE of item 2 -> next cycle leds=0, state INICIAL, no pronto; fresh iniciar then runs normally.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared constants and state encodings for the genius memory-game blocks.
// Data and address are 4 bits wide: a 16-entry RAM that holds 4-bit LED patterns.
package genius_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 4;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        ESPERA_MEM = 4'd1,
        CAPTURA    = 4'd2,
        ACENDE     = 4'd3,
        APAGA      = 4'd4,
        FIM        = 4'd5
    } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with a synchronous clear and a count enable.
// When clear and enable are both high in the same cycle, clear wins.
module contador_m #(
    parameter int M = 4,
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] Q
);

    localparam logic [N-1:0] LAST = N'(M - 1);

    logic [N-1:0] r_q;

    always_ff @(posedge clock) begin
        if (zera_s) begin
            r_q <= '0;
        end else if (conta) begin
            if (r_q == LAST) r_q <= '0;
            else             r_q <= r_q + 1'b1;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/exibe_sequencia.sv
// Plays back items 0..rodada from an external sync RAM on the LEDs:
// each item is lit for T_ON cycles, followed by a dark gap of T_OFF cycles.
module exibe_sequencia
    import genius_pkg::*;
#(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] rodada,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [DATA_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [ADDR_W-1:0] db_endereco,
    output logic [3:0]        db_estado
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    estado_t           r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rodada;
    logic [DATA_W-1:0] r_leds;
    logic              r_pronto;

    logic [TW-1:0] w_timer;
    logic          w_fim_on;
    logic          w_fim_off;
    logic          w_zera;
    logic          w_conta;

    assign w_fim_on  = (r_state == ACENDE) && (w_timer == ON_LAST);
    assign w_fim_off = (r_state == APAGA)  && (w_timer == OFF_LAST);
    // CAPTURA clears ahead of ACENDE; the ACENDE exit clears ahead of APAGA.
    assign w_zera    = reset || (r_state == CAPTURA) || w_fim_on || w_fim_off;
    assign w_conta   = (r_state == ACENDE) || (r_state == APAGA);

    contador_m #(
        .M (T_MAX),
        .N (TW)
    ) u_timer (
        .clock  (clock),
        .zera_s (w_zera),
        .conta  (w_conta),
        .Q      (w_timer)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= INICIAL;
            r_addr   <= '0;
            r_rodada <= '0;
            r_leds   <= '0;
            r_pronto <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_state)
                INICIAL: begin
                    if (iniciar) begin
                        r_addr   <= '0;
                        r_rodada <= rodada;
                        r_state  <= ESPERA_MEM;
                    end
                end
                ESPERA_MEM: r_state <= CAPTURA;
                CAPTURA: begin
                    r_leds  <= mem_dado;
                    r_state <= ACENDE;
                end
                ACENDE: begin
                    if (w_fim_on) begin
                        r_leds  <= '0;
                        r_state <= APAGA;
                    end
                end
                APAGA: begin
                    if (w_fim_off) begin
                        if (r_addr == r_rodada) begin
                            r_pronto <= 1'b1;
                            r_state  <= FIM;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= ESPERA_MEM;
                        end
                    end
                end
                FIM:     r_state <= INICIAL;
                default: r_state <= INICIAL;
            endcase
        end
    end

    assign mem_addr    = r_addr;
    assign db_endereco = r_addr;
    assign leds        = r_leds;
    assign pronto      = r_pronto;
    assign exibindo    = (r_state != INICIAL);
    assign db_estado   = r_state;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia with T_ON=4, T_OFF=2 and a sync RAM preloaded 1,2,4,8,...
module tb_exibe_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int ITEM  = 2 + T_ON + T_OFF;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] rodada;
    logic [3:0] mem_addr;
    logic [3:0] mem_dado;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [3:0] db_endereco;
    logic [3:0] db_estado;

    logic [3:0] ram [16];
    logic [3:0] exp_q [$];
    int n_vec;
    int n_err;

    exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .rodada      (rodada),
        .mem_addr    (mem_addr),
        .mem_dado    (mem_dado),
        .leds        (leds),
        .exibindo    (exibindo),
        .pronto      (pronto),
        .db_endereco (db_endereco),
        .db_estado   (db_estado)
    );

    // clock / reset block and RAM model (1-cycle read latency)
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) mem_dado <= ram[mem_addr];

    // expected state, c = cycles after the edge that sampled iniciar
    function automatic logic [3:0] exp_state(input int c, input int last);
        int o;
        if (c == last) return 4'd5;
        if (c > last)  return 4'd0;
        o = c % ITEM;
        if (o == 0) return 4'd1;
        if (o == 1) return 4'd2;
        if (o <= 1 + T_ON) return 4'd3;
        return 4'd4;
    endfunction

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0; rodada = 4'd0;
        repeat (3) @(negedge clock);
        n_vec++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL reset_state got=%h exp=0", db_estado); end
        n_vec++; if (leds !== 4'd0) begin n_err++; $display("FAIL reset_leds got=%h exp=0", leds); end
        n_vec++; if (pronto !== 1'b0) begin n_err++; $display("FAIL reset_pronto got=%b exp=0", pronto); end
        n_vec++; if (exibindo !== 1'b0) begin n_err++; $display("FAIL reset_exibindo got=%b exp=0", exibindo); end
        n_vec++; if (mem_addr !== 4'd0 || db_endereco !== 4'd0) begin n_err++; $display("FAIL reset_addr got=%h/%h exp=0", mem_addr, db_endereco); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    // One full run; the scoreboard holds the LED pattern of each item.
    // rodada is scrambled after sampling, so a re-sample would change the run length.
    task automatic test_sequence(input logic [3:0] r, input bit hold);
        int last;
        int o;
        int k;
        logic [3:0] lit;
        logic [3:0] exp_leds;
        logic [3:0] exp_addr;
        last = ITEM * (int'(r) + 1);
        lit = 4'd0;
        for (int i = 0; i <= int'(r); i++) exp_q.push_back(ram[i]);
        @(negedge clock);
        iniciar = 1'b1; rodada = r;
        @(posedge clock);
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clock);
            if (!hold) iniciar = 1'b0;
            if (c == 3) rodada = ~r;
            o = c % ITEM;
            k = c / ITEM;
            if (c < last && o == 2) begin
                n_vec++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL scoreboard_empty c=%0d", c); end
                else lit = exp_q.pop_front();
            end
            exp_leds = (c < last && o >= 2 && o <= 1 + T_ON) ? lit : 4'd0;
            exp_addr = (c < last) ? 4'(k) : r;
            n_vec++; if (leds !== exp_leds) begin n_err++; $display("FAIL leds r=%0d c=%0d got=%h exp=%h", r, c, leds, exp_leds); end
            n_vec++; if (db_estado !== exp_state(c, last)) begin n_err++; $display("FAIL state r=%0d c=%0d got=%h exp=%h", r, c, db_estado, exp_state(c, last)); end
            n_vec++; if (pronto !== (c == last)) begin n_err++; $display("FAIL pronto r=%0d c=%0d got=%b exp=%b", r, c, pronto, (c == last)); end
            n_vec++; if (exibindo !== (c <= last)) begin n_err++; $display("FAIL exibindo r=%0d c=%0d got=%b exp=%b", r, c, exibindo, (c <= last)); end
            n_vec++; if (mem_addr !== exp_addr || db_endereco !== exp_addr) begin n_err++; $display("FAIL addr r=%0d c=%0d got=%h/%h exp=%h", r, c, mem_addr, db_endereco, exp_addr); end
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left r=%0d got=%0d exp=0", r, exp_q.size()); end
        exp_q.delete();
    endtask

    // iniciar held high: only a single run, then a restart from INICIAL
    task automatic test_hold_iniciar();
        test_sequence(4'd2, 1'b1);
        @(negedge clock);
        n_vec++; if (db_estado !== 4'd1) begin n_err++; $display("FAIL hold_restart got=%h exp=1", db_estado); end
        iniciar = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_abort();
        int npr;
        for (int i = 0; i <= 3; i++) exp_q.push_back(ram[i]);
        @(negedge clock);
        iniciar = 1'b1; rodada = 4'd3;
        @(posedge clock);
        for (int c = 0; c <= 2 * ITEM + 3; c++) begin
            @(negedge clock);
            iniciar = 1'b0;
        end
        n_vec++; if (db_estado !== 4'd3 || leds !== ram[2]) begin n_err++; $display("FAIL abort_pre got=%h/%h exp=3/%h", db_estado, leds, ram[2]); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        n_vec++; if (leds !== 4'd0) begin n_err++; $display("FAIL abort_leds got=%h exp=0", leds); end
        n_vec++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL abort_state got=%h exp=0", db_estado); end
        n_vec++; if (exibindo !== 1'b0) begin n_err++; $display("FAIL abort_exibindo got=%b exp=0", exibindo); end
        npr = 0;
        for (int c = 0; c < 3 * ITEM; c++) begin
            if (pronto === 1'b1) npr++;
            @(negedge clock);
        end
        n_vec++; if (npr != 0 || db_estado !== 4'd0) begin n_err++; $display("FAIL abort_no_pronto got=%0d/%h exp=0/0", npr, db_estado); end
        test_sequence(4'd1, 1'b0);
    endtask

    task automatic test_reset_priority();
        @(negedge clock);
        reset = 1'b1; iniciar = 1'b1; rodada = 4'd5;
        @(negedge clock);
        n_vec++; if (db_estado !== 4'd0 || exibindo !== 1'b0) begin n_err++; $display("FAIL prio_state got=%h/%b exp=0/0", db_estado, exibindo); end
        reset = 1'b0; iniciar = 1'b0;
        @(negedge clock);
        n_vec++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL prio_idle got=%h exp=0", db_estado); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) ram[i] = 4'(1 << (i % 4));
        reset = 1'b1; iniciar = 1'b0; rodada = 4'd0;
        test_reset();
        test_sequence(4'd0, 1'b0);
        test_sequence(4'd3, 1'b0);
        for (int i = 0; i < 16; i++) ram[i] = 4'($urandom_range(1, 15));
        test_sequence(4'd15, 1'b0);
        test_sequence(4'($urandom_range(4, 9)), 1'b0);
        test_hold_iniciar();
        test_reset_abort();
        test_reset_priority();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
